mips_avalon_arbiter: RTL
========================

# mips_avalon_arbiter

Two-port arbiter and Avalon memory-mapped master that lets the CPU instruction-fetch port and data port share the single Avalon slave memory. It sits directly upstream of the memory slave. Each granted request is registered, then driven onto the bus and held stable until the slave completes it. The result is returned to the requesting port with a one-cycle acknowledge pulse.

## Interface
Parameters:
- READ_LATENCY, 1: cycles spent in RD_WAIT after a read is accepted; readdata is captured at the end of the last RD_WAIT cycle.
- WRITE_HOLD, 1: cycles address/writedata/byteenable stay held (write low) after a write is accepted.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  reset. One clock; reset is synchronous and active-low.
- i_req  in  1  instruction fetch request; i_addr held stable until i_ack.
- i_addr  in  32  fetch byte address.
- i_ack  out  1  one-cycle completion pulse for the fetch port.
- i_err  out  1  valid with i_ack; 1 = misaligned request rejected.
- i_rdata  out  32  fetched word; valid while i_ack=1.
- d_req  in  1  data request; d_we/d_addr/d_wdata/d_be held until d_ack.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  32  data byte address.
- d_wdata  in  32  write data.
- d_be  in  4  write byte enables.
- d_ack  out  1  one-cycle completion pulse for the data port.
- d_err  out  1  valid with d_ack; misaligned rejection.
- d_rdata  out  32  read word; valid while d_ack=1.
- address  out  32  Avalon address.
- read  out  1  Avalon read.
- write  out  1  Avalon write.
- writedata  out  32  Avalon write data.
- byteenable  out  4  Avalon byte enables.
- waitrequest  in  1  Avalon stall.
- readdata  in  32  Avalon read data.

## Operation
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_HOLD, ACK.
- **IDLE, arbitration**
  - Pick a requester; register its fields and owner into an internal transaction record.
  - Fields are sampled only here; later requester changes are ignored.
  - Both requesting: grant the port not granted last. last_grant resets to "data", so the fetch port wins the first tie.
  - One requesting: grant it.
- **IDLE, next state**
  - Address bits [1:0] != 0: go to ACK with err=1 and rdata=0. No bus cycle is issued.
  - Aligned fetch, or data with d_we=0: go to RD_REQ.
  - Aligned data with d_we=1: go to WR_REQ.
- **RD_REQ**
  - Drive read=1, address=registered address, byteenable=4'b1111.
  - Stay while waitrequest=1.
  - When waitrequest=0 the read is accepted at that edge: read→0, go to RD_WAIT.
- **RD_WAIT**
  - Count READ_LATENCY cycles; address stays held.
  - Capture readdata at the final edge; go to ACK.
- **WR_REQ**
  - Drive write=1 with address, writedata and byteenable taken from the record.
  - Stay while waitrequest=1.
  - When waitrequest=0, write→0 and go to WR_HOLD.
- **WR_HOLD**
  - Hold address, writedata and byteenable for WRITE_HOLD cycles (the slave commits during this window), then go to ACK.
- **ACK** (exactly one cycle)
  - Pulse the owner's ack; drive the owner's rdata (captured word, or 0 on writes and errors) and err.
  - Update last_grant; go to IDLE.
- Outputs while idle:
  - read and write are 0.
  - address, writedata and byteenable retain their last driven values.
  - i_rdata and d_rdata retain their last values.
- A requester keeping req high after ack makes a new request, arbitrated in the following IDLE cycle.
- read and write are never high together; only one transaction is outstanding.

## Timing
- **Reset:** rst_n low at an edge returns all of the following, from the next cycle:
  - state=IDLE, last_grant=data;
  - read, write, i_ack, d_ack, i_err, d_err = 0;
  - address, writedata, i_rdata, d_rdata = 0; byteenable=0.
- **Reset mid-transaction:** aborts the transaction with no ack; the bus drops read/write next cycle.
- **Read latency** (grant cycle counted as cycle 0, waitrequest high for W cycles):
  - read is high in cycles 1..W+1;
  - RD_WAIT occupies READ_LATENCY cycles;
  - ack arrives in cycle W+2+READ_LATENCY.
- **Write latency:** ack arrives in cycle W+2+WRITE_HOLD.
- **Misaligned request:** ack with err=1 in cycle 1.
- **Zero-wait slave:** read=1 for one cycle only.
- **Request dropped before ack:** this is a protocol violation. The transaction still completes and the ack is still pulsed.
- **Back-to-back:** a new grant can occur in the IDLE cycle right after ACK, so there is a minimum of 1 idle bus cycle between transactions.

## Test plan
- **Fetch read:** slave with 2-cycle read wait, READ_LATENCY=1; i_req, i_addr=0xBFC00000, word 0x3C011234 → read high for 3 cycles, i_ack in cycle 5, i_rdata=0x3C011234, i_err=0, d_ack=0.
- **Data write then read-back:** write d_addr=0x10, d_wdata=0xAABBCCDD, d_be=4'b0101 over prior contents 0x11223344 → address/writedata held through WR_HOLD; a following read of 0x10 returns 0x11BB33DD.
- **Simultaneous requests after reset:** i_req and d_req both high → fetch served first, then data. A second tie with both still requesting → fetch, data again, alternating.
- **Misaligned request:** d_addr=0x12 → d_ack with d_err=1 in cycle 1, d_rdata=0, read and write never asserted.
- **Zero-wait slave:** back-to-back reads of 0x0 and 0x4 → one read cycle each, acks 4 cycles apart, correct data.
- **Reset mid-operation:** rst_n low during a WR_REQ waitrequest → next cycle write=0, no d_ack; after release a new fetch completes normally.

Source files
------------

// File: rtl/mips_avalon_arbiter.sv
// rtl/mips_avalon_arbiter.sv - fetch/data port arbiter and Avalon-MM master
// One transaction at a time; ties alternate, starting with the fetch port after reset.
module mips_avalon_arbiter #(
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned WRITE_HOLD   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic        i_err,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_HOLD, ACK} state_t;
  typedef enum logic {OWN_FETCH, OWN_DATA} owner_t;

  state_t      state_q;
  owner_t      owner_q;
  owner_t      last_grant_q;
  logic [15:0] cnt_q;
  logic        read_q;
  logic        write_q;
  logic [31:0] address_q;
  logic [31:0] writedata_q;
  logic [3:0]  byteenable_q;
  logic        i_ack_q;
  logic        i_err_q;
  logic [31:0] i_rdata_q;
  logic        d_ack_q;
  logic        d_err_q;
  logic [31:0] d_rdata_q;

  logic        grant_any;
  logic        grant_fetch;
  logic        grant_write;
  logic        grant_misaligned;
  logic [31:0] grant_addr;

  always_comb begin
    grant_any        = i_req | d_req;
    grant_fetch      = i_req & (~d_req | (last_grant_q == OWN_DATA));
    grant_addr       = grant_fetch ? i_addr : d_addr;
    grant_write      = ~grant_fetch & d_we;
    grant_misaligned = grant_addr[1:0] != 2'b00;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= OWN_DATA;
      last_grant_q <= OWN_DATA;
      cnt_q        <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      address_q    <= '0;
      writedata_q  <= '0;
      byteenable_q <= '0;
      i_ack_q      <= 1'b0;
      i_err_q      <= 1'b0;
      i_rdata_q    <= '0;
      d_ack_q      <= 1'b0;
      d_err_q      <= 1'b0;
      d_rdata_q    <= '0;
    end else begin
      // Acknowledge and error are single-cycle; only the transition into ACK raises them.
      i_ack_q <= 1'b0;
      i_err_q <= 1'b0;
      d_ack_q <= 1'b0;
      d_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            owner_q <= grant_fetch ? OWN_FETCH : OWN_DATA;
            if (grant_misaligned) begin
              state_q <= ACK;
              if (grant_fetch) begin
                i_ack_q   <= 1'b1;
                i_err_q   <= 1'b1;
                i_rdata_q <= '0;
              end else begin
                d_ack_q   <= 1'b1;
                d_err_q   <= 1'b1;
                d_rdata_q <= '0;
              end
            end else if (grant_write) begin
              state_q      <= WR_REQ;
              write_q      <= 1'b1;
              address_q    <= grant_addr;
              writedata_q  <= d_wdata;
              byteenable_q <= d_be;
            end else begin
              state_q      <= RD_REQ;
              read_q       <= 1'b1;
              address_q    <= grant_addr;
              byteenable_q <= 4'b1111;
            end
          end
        end
        RD_REQ: begin
          if (!waitrequest) begin
            read_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (cnt_q == 16'(READ_LATENCY - 1)) begin
            state_q <= ACK;
            if (owner_q == OWN_FETCH) begin
              i_ack_q   <= 1'b1;
              i_rdata_q <= readdata;
            end else begin
              d_ack_q   <= 1'b1;
              d_rdata_q <= readdata;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        WR_REQ: begin
          if (!waitrequest) begin
            write_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= WR_HOLD;
          end
        end
        WR_HOLD: begin
          if (cnt_q == 16'(WRITE_HOLD - 1)) begin
            state_q <= ACK;
            if (owner_q == OWN_FETCH) begin
              i_ack_q   <= 1'b1;
              i_rdata_q <= '0;
            end else begin
              d_ack_q   <= 1'b1;
              d_rdata_q <= '0;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        ACK: begin
          last_grant_q <= owner_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign address    = address_q;
  assign read       = read_q;
  assign write      = write_q;
  assign writedata  = writedata_q;
  assign byteenable = byteenable_q;
  assign i_ack      = i_ack_q;
  assign i_err      = i_err_q;
  assign i_rdata    = i_rdata_q;
  assign d_ack      = d_ack_q;
  assign d_err      = d_err_q;
  assign d_rdata    = d_rdata_q;

endmodule
